// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath widths.
// Imported by the ALU, its decoder and the ALU arbiter.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 4;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU.
// Undefined opcodes produce zero.
module alu #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    output logic [DATA_WIDTH-1:0] res_o
);
    import alu_pkg::*;

    alu_op_e    op;
    logic [4:0] shamt;

    assign op    = alu_op_e'(op_i);
    assign shamt = b_i[4:0];

    always_comb begin
        res_o = '0;
        case (op)
            ALU_ADD:    res_o = a_i + b_i;
            ALU_SUB:    res_o = a_i - b_i;
            ALU_SLL:    res_o = a_i << shamt;
            ALU_SLT:    res_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
            ALU_SLTU:   res_o = DATA_WIDTH'(a_i < b_i);
            ALU_XOR:    res_o = a_i ^ b_i;
            ALU_SRL:    res_o = a_i >> shamt;
            ALU_SRA:    res_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:     res_o = a_i | b_i;
            ALU_AND:    res_o = a_i & b_i;
            ALU_PASS_B: res_o = b_i;
            default:    res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, with a
// registered per-requester response slot held until consumed.
module alu_arbiter #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int NUM_REQ    = 2,
    parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_res_o,
    output logic                           busy_o
);
    import alu_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_res_q, rsp_res_d;

    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      g_idx;
    logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [OP_WIDTH-1:0]   alu_op;

    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr
    );
        logic [NUM_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // A slot being drained this cycle can accept a new result.
    assign elig  = req_valid_i & (~rsp_valid_q | rsp_ready_i);
    assign grant = rst_n ? rr_pick(elig, rr_ptr_q) : '0;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g_idx = PTR_W'(i);
        end
    end

    assign alu_a  = req_a_i[g_idx*DATA_WIDTH +: DATA_WIDTH];
    assign alu_b  = req_b_i[g_idx*DATA_WIDTH +: DATA_WIDTH];
    assign alu_op = req_op_i[g_idx*OP_WIDTH +: OP_WIDTH];

    alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH)
    ) u_alu (
        .a_i   (alu_a),
        .b_i   (alu_b),
        .op_i  (alu_op),
        .res_o (alu_res)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = grant | (rsp_valid_q & ~rsp_ready_i);
        rsp_res_d   = rsp_res_q;
        if (|grant) begin
            if (g_idx == PTR_W'(NUM_REQ - 1)) rr_ptr_d = '0;
            else                              rr_ptr_d = g_idx + 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) rsp_res_d[i] = alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
        end
    end

    assign req_ready_o = grant;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_res_o   = rsp_res_q;
    assign busy_o      = |rsp_valid_q;

endmodule
